uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Single-clock UART frame receiver. It oversamples the serial line at 16× baud and validates start, parity and stop bits. Each received character is delivered through a valid/ready handshake with per-frame error flags. It is the clk-domain receive endpoint paired with the existing transmitter, replacing the separate derived-clock receive path, and needs no external rx_start qualifier.

## Interface
- SYNC_STAGES, 2, flops in the rxd input synchronizer (≥2)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- div  in  16  clk cycles per oversample tick, minus one (0 = tick every cycle)
- length  in  4  data bits per frame; 5..8, any other value treated as 8
- parity_en  in  1  parity bit present after data
- parity_type  in  1  1: parity = XOR of data bits; 0: XNOR (matches transmitter)
- stop2  in  1  two stop bits expected
- rxd  in  1  serial line, idle high, asynchronous
- data  out  8  received character, right-aligned, unused MSBs zero
- data_valid  out  1  data and flags are valid
- data_ready  in  1  consumer accepts when data_valid && data_ready
- parity_err  out  1  parity mismatch, qualified by data_valid
- frame_err  out  1  a stop bit sampled low, qualified by data_valid
- break_det  out  1  all data/parity/stop bits low, qualified by data_valid
- overrun  out  1  one-cycle pulse: completed frame dropped because data_valid was still high
- busy  out  1  FSM not in IDLE

## Operation
- Tick: counter 0..div; one-cycle tick when the count equals div, then wraps to 0. Counter and tick are held at 0 in IDLE. The counter restarts at the start-edge detection cycle.
- Sample counter sc runs 0..15 per bit on ticks. Bit value is decided at sc==9 (see Configuration).
- IDLE: synced rxd==0 → START, sc=0.
- START: decision 1 → IDLE (glitch, nothing reported). Decision 0 → DATA at sc wrap.
- DATA: LSB first; shift in `length` bits, bit counter 0..length-1. Then go to PARITY if parity_en, else STOP1.
- PARITY: compare the sampled bit against the computed parity; a mismatch sets parity_err.
- STOP1: at decision:
  - stop2=0: complete the frame.
  - stop2=1: wait for sc wrap → STOP2, then complete at the STOP2 decision.
  - Either stop sampled 0 sets frame_err.
- Completion:
  - Any stop bit 0 → WAIT_IDLE, otherwise → IDLE.
  - WAIT_IDLE → IDLE once synced rxd==1.
- break_det = frame_err && data==0 && (parity bit 0 or !parity_en).
- Output register load:
  - Loads data and flags on completion if !data_valid, or if data_valid && data_ready in the same cycle.
  - Otherwise the frame is dropped, old data is kept and overrun pulses.
- length, parity_en, parity_type, stop2 and div are sampled at start detection and held for the frame. Mid-frame input changes are ignored.
- rst mid-frame: FSM → IDLE, partial frame discarded, no outputs asserted.

## Timing
- Reset values: data=0, data_valid=0, parity_err=0, frame_err=0, break_det=0, overrun=0, busy=0.
- Input latency: SYNC_STAGES cycles from rxd to FSM.
- data_valid rises the cycle after the completion tick and stays high until the handshake.
- After the handshake cycle, data_valid falls next cycle unless a frame completes in that same cycle. In that case it stays high with new data.
- Frame length = 16 ticks × (1 + length + parity_en + 1 + stop2). Completion occurs about 7 ticks before the nominal end of the final stop bit, which allows back-to-back frames.

## Configuration
- UART_RX_MAJORITY_EN defined: bit value = majority of the samples at sc 7, 8 and 9, decided at sc==9.
- UART_RX_MAJORITY_EN undefined: bit value = the single sample at sc==8, latched and acted on at sc==9 so all cycle timing is identical in both builds.

## Structure
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE
  - OVERSAMPLE=16, SAMPLE_MID=8
  - parity_calc function (data, length, parity_type)
- Sub-module uart_baud_tick: divisor counter producing the tick, with clear input.

## Test plan
- div=0, length=8, no parity, stop2=0, send 0xA5 → data=0xA5, data_valid 1, all error flags 0, single frame.
- length=5, parity_en=1, parity_type=1, send 0x13 with correct parity → data=0x13, parity_err=0; repeat with the parity bit flipped → parity_err=1.
- stop2=1 with the second stop bit driven 0 → frame_err=1, break_det=0, FSM waits in WAIT_IDLE until rxd=1.
- rxd held low for 2 frame times → data=0x00, frame_err=1, break_det=1, exactly one frame reported.
- data_ready=0, two back-to-back frames 0x11 then 0x22 → data stays 0x11, overrun pulses once; with data_ready=1 both are delivered in order.
- 4-tick low glitch on idle rxd → no data_valid, busy returns to 0; rst asserted mid-DATA → all outputs 0 next cycle, a following frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver.
//   state_t      - receiver FSM states
//   OVERSAMPLE   - oversample ticks per bit
//   SAMPLE_MID   - nominal mid-bit sample index
//   SC_*         - 4-bit sample-counter compare points derived from the above
//   parity_calc  - parity over the low `length` bits (XOR when parity_type=1, XNOR otherwise)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    localparam logic [3:0] SC_EARLY  = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] SC_MID    = 4'(SAMPLE_MID);
    localparam logic [3:0] SC_DECIDE = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] SC_LAST   = 4'(OVERSAMPLE - 1);

    function automatic logic parity_calc(input logic [7:0] data,
                                         input logic [3:0] length,
                                         input logic       parity_type);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(length)) begin
                x = x ^ data[i];
            end
        end
        return parity_type ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - holds the counter and the tick at zero while high
//   div       - cycles per tick minus one (0 = tick every cycle)
//   tick      - one-cycle pulse when the count equals div
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_reg;

    assign tick = !clear && (cnt_reg == div);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == div) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver, 16x oversampled, single clock domain.
// Delivers each character on a valid/ready handshake with parity, framing
// and break flags; drops a completed frame (overrun pulse) if the previous
// one has not been taken.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by majority
// of samples 7/8/9; otherwise the single sample at 8 is used. Both builds
// act on the decision at sample 9, so cycle timing is identical.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   div                      - clk cycles per oversample tick minus one
//   length                   - data bits 5..8 (other values mean 8)
//   parity_en, parity_type   - parity present / 1=XOR, 0=XNOR
//   stop2                    - two stop bits expected
//   rxd                      - asynchronous serial input, idle high
//   data, data_valid, data_ready - character output handshake
//   parity_err, frame_err, break_det - per-frame flags, qualified by data_valid
//   overrun                  - one-cycle pulse when a frame is dropped
//   busy                     - FSM not idle
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] div,
    input  logic [3:0]  length,
    input  logic        parity_en,
    input  logic        parity_type,
    input  logic        stop2,
    input  logic        rxd,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        break_det,
    output logic        overrun,
    output logic        busy
);

    // ---------------- input synchronizer (idle high) ----------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxd_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= rxd;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rxd_s = sync_reg[SYNC_STAGES-1];

    // ---------------- state and per-frame configuration ----------------
    state_t      state_reg, state_next;
    logic        start_det;
    logic [2:0]  len_m1_reg;
    logic        pen_reg, ptype_reg, stop2_reg;
    logic [15:0] div_reg;

    assign start_det = (state_reg == IDLE) && !rxd_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_m1_reg <= 3'd7;
            pen_reg    <= 1'b0;
            ptype_reg  <= 1'b0;
            stop2_reg  <= 1'b0;
            div_reg    <= '0;
        end else if (start_det) begin
            len_m1_reg <= (length >= 4'd5 && length <= 4'd8) ? 3'(length - 4'd1) : 3'd7;
            pen_reg    <= parity_en;
            ptype_reg  <= parity_type;
            stop2_reg  <= stop2;
            div_reg    <= div;
        end
    end

    // Tick counter is held cleared in IDLE, so it restarts on the detection cycle.
    logic tick;

    uart_baud_tick u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_reg == IDLE),
        .div   (div_reg),
        .tick  (tick)
    );

    // ---------------- sample counter and bit decision ----------------
    logic [3:0] sc_reg;
    logic       s8_reg;
    logic       bit_val;
    logic       decide, wrap;

    assign decide = tick && (sc_reg == SC_DECIDE);
    assign wrap   = tick && (sc_reg == SC_LAST);

    always_ff @(posedge clk) begin
        if (rst || start_det) begin
            sc_reg <= '0;
        end else if (tick) begin
            sc_reg <= sc_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s8_reg <= 1'b1;
        end else if (tick && sc_reg == SC_MID) begin
            s8_reg <= rxd_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s7_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s7_reg <= 1'b1;
        end else if (tick && sc_reg == SC_EARLY) begin
            s7_reg <= rxd_s;
        end
    end

    // Third vote is the live sample taken at the decision tick.
    assign bit_val = (s7_reg & s8_reg) | (s7_reg & rxd_s) | (s8_reg & rxd_s);
`else
    assign bit_val = s8_reg;
`endif

    // ---------------- frame datapath ----------------
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       par_bit_reg;
    logic       stop_bad_reg;

    always_ff @(posedge clk) begin
        if (rst || start_det) begin
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            stop_bad_reg <= 1'b0;
        end else begin
            if (state_reg == DATA && decide) shift_reg[bit_cnt_reg] <= bit_val;
            if (state_reg == DATA && wrap)   bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (state_reg == PARITY && decide) par_bit_reg <= bit_val;
            if (state_reg == STOP1 && decide)  stop_bad_reg <= !bit_val;
        end
    end

    // ---------------- FSM next state ----------------
    logic complete;

    always_comb begin
        state_next = state_reg;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxd_s) state_next = START;
            end
            START: begin
                if (decide && bit_val) state_next = IDLE;   // glitch
                else if (wrap)         state_next = DATA;
            end
            DATA: begin
                if (wrap && bit_cnt_reg == len_m1_reg) state_next = pen_reg ? PARITY : STOP1;
            end
            PARITY: begin
                if (wrap) state_next = STOP1;
            end
            STOP1: begin
                if (decide && !stop2_reg) begin
                    complete   = 1'b1;
                    state_next = bit_val ? IDLE : WAIT_IDLE;
                end else if (wrap && stop2_reg) begin
                    state_next = STOP2;
                end
            end
            STOP2: begin
                if (decide) begin
                    complete   = 1'b1;
                    state_next = (bit_val && !stop_bad_reg) ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Flags as they would be reported by a frame completing this cycle.
    logic fe_now, pe_now, bd_now;

    assign fe_now = !bit_val || stop_bad_reg;
    assign pe_now = pen_reg &&
                    (par_bit_reg != parity_calc(shift_reg, {1'b0, len_m1_reg} + 4'd1, ptype_reg));
    assign bd_now = fe_now && (shift_reg == 8'h00) && (!pen_reg || !par_bit_reg);

    // ---------------- output register ----------------
    logic [7:0] data_reg;
    logic       valid_reg, pe_reg, fe_reg, bd_reg, ovr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            pe_reg    <= 1'b0;
            fe_reg    <= 1'b0;
            bd_reg    <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            ovr_reg <= 1'b0;
            if (complete && (!valid_reg || data_ready)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
                pe_reg    <= pe_now;
                fe_reg    <= fe_now;
                bd_reg    <= bd_now;
            end else if (complete) begin
                ovr_reg <= 1'b1;
            end else if (valid_reg && data_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data       = data_reg;
    assign data_valid = valid_reg;
    assign parity_err = pe_reg;
    assign frame_err  = fe_reg;
    assign break_det  = bd_reg;
    assign overrun    = ovr_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: drives serial frames bit by bit and
// checks the delivered character and flags against hand-computed values.
module tb_uart_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd0;
    logic [3:0]  length = 4'd8;
    logic        parity_en = 1'b0;
    logic        parity_type = 1'b1;
    logic        stop2 = 1'b0;
    logic        rxd = 1'b1;
    logic [7:0]  data;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        parity_err, frame_err, break_det, overrun, busy;

    int tests = 0;
    int fails = 0;
    int bit_cycles = 16;
    int ovr_cnt = 0;
    int rise_cnt = 0;
    logic dv_prev = 1'b0;
    logic [7:0] accepted[$];

    uart_frame_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .div         (div),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .rxd         (rxd),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Observes handshakes, overrun pulses and data_valid rises mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && data_ready) accepted.push_back(data);
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (data_valid && !dv_prev) rise_cnt <= rise_cnt + 1;
        end
        dv_prev <= data_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        step(bit_cycles);
    endtask

    // start, nbits data LSB first, optional parity, stop1, optional stop2.
    // rxd is left at the last stop value.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic pbit, input logic s1, input logic s2,
                              input logic two_stop);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(s1);
        if (two_stop) send_bit(s2);
        $display("[TB] sent frame %02h (%0d bits)", d, nbits);
    endtask

    task automatic accept();
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                               input logic fe, input logic bd);
        check({tag, ".valid"}, 32'(data_valid), 32'd1);
        check({tag, ".data"},  32'(data),       32'(d));
        check({tag, ".pe"},    32'(parity_err), 32'(pe));
        check({tag, ".fe"},    32'(frame_err),  32'(fe));
        check({tag, ".bd"},    32'(break_det),  32'(bd));
    endtask

    initial begin
        int r0;
        int o0;
        logic [7:0] a0, a1;

        // ---- reset ----
        step(3);
        check("rst.data",  32'(data),       32'd0);
        check("rst.valid", 32'(data_valid), 32'd0);
        check("rst.pe",    32'(parity_err), 32'd0);
        check("rst.fe",    32'(frame_err),  32'd0);
        check("rst.bd",    32'(break_det),  32'd0);
        check("rst.ovr",   32'(overrun),    32'd0);
        check("rst.busy",  32'(busy),       32'd0);
        rst = 1'b0;
        step(5);

        // ---- 8N1, 0xA5 ----
        r0 = rise_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5.rises", 32'(rise_cnt - r0), 32'd1);
        accept();
        check("a5.drop", 32'(data_valid), 32'd0);
        step(5);

        // ---- 5 bits, XOR parity: 0x13 -> 1,1,0,0,1 -> parity 1 ----
        length = 4'd5; parity_en = 1'b1; parity_type = 1'b1;
        send_frame(8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_frame("par_ok", 8'h13, 1'b0, 1'b0, 1'b0);
        accept();
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("par_bad", 8'h13, 1'b1, 1'b0, 1'b0);
        accept();
        step(5);

        // ---- two stop bits, second low: frame error, waits for idle ----
        length = 4'd8; parity_en = 1'b0; stop2 = 1'b1;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(40);
        check("stop2.busy", 32'(busy), 32'd1);
        check_frame("stop2", 8'h5A, 1'b0, 1'b1, 1'b0);
        accept();
        rxd = 1'b1;
        step(5);
        check("stop2.idle", 32'(busy), 32'd0);
        stop2 = 1'b0;
        step(5);

        // ---- break: low for two frame times ----
        r0 = rise_cnt;
        rxd = 1'b0;
        step(320);
        check("brk.rises", 32'(rise_cnt - r0), 32'd1);
        check_frame("brk", 8'h00, 1'b0, 1'b1, 1'b1);
        accept();
        step(20);
        check("brk.nomore", 32'(data_valid), 32'd0);
        check("brk.wait", 32'(busy), 32'd1);
        rxd = 1'b1;
        step(5);
        check("brk.idle", 32'(busy), 32'd0);

        // ---- overrun: two frames, not accepted ----
        o0 = ovr_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(3);
        check("ovr.cnt", 32'(ovr_cnt - o0), 32'd1);
        check_frame("ovr", 8'h11, 1'b0, 1'b0, 1'b0);
        accept();
        step(3);

        // ---- ready held high: back-to-back frames delivered in order ----
        accepted.delete();
        o0 = ovr_cnt;
        data_ready = 1'b1;
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(3);
        data_ready = 1'b0;
        a0 = (accepted.size() > 0) ? accepted[0] : 8'h00;
        a1 = (accepted.size() > 1) ? accepted[1] : 8'h00;
        check("rdy.count", 32'(accepted.size()), 32'd2);
        check("rdy.first", 32'(a0), 32'h33);
        check("rdy.second", 32'(a1), 32'h44);
        check("rdy.noovr", 32'(ovr_cnt - o0), 32'd0);
        check("rdy.drop", 32'(data_valid), 32'd0);

        // ---- 4-cycle glitch on idle line ----
        r0 = rise_cnt;
        rxd = 1'b0;
        step(4);
        check("glitch.busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        step(30);
        check("glitch.idle", 32'(busy), 32'd0);
        check("glitch.valid", 32'(data_valid), 32'd0);
        check("glitch.rises", 32'(rise_cnt - r0), 32'd0);

        // ---- out-of-range length behaves as 8 ----
        length = 4'd3;
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("len3", 8'h96, 1'b0, 1'b0, 1'b0);
        length = 4'd8;
        // left pending on purpose for the reset test

        // ---- reset mid-DATA ----
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rxd = 1'b1;
        rst = 1'b1;
        step(1);
        check("mrst.valid", 32'(data_valid), 32'd0);
        check("mrst.data",  32'(data),       32'd0);
        check("mrst.fe",    32'(frame_err),  32'd0);
        check("mrst.busy",  32'(busy),       32'd0);
        step(1);
        rst = 1'b0;
        step(10);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("mrst.next", 8'h3C, 1'b0, 1'b0, 1'b0);
        accept();
        step(5);

        // ---- slower tick: div=2 ----
        div = 16'd2;
        bit_cycles = 48;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_frame("div2", 8'hC3, 1'b0, 1'b0, 1'b0);
        accept();
        check("div2.drop", 32'(data_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
